iscas89_bist_harness: RTL and testbench



---
 rtl/iscas89_bist_harness.sv | 142 ++++++++++++++
 tb/tb_iscas89_bist_harness.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iscas89_bist_harness.sv
// Pad-level BIST harness for ISCAS89 cores: functional pass-through, or an LFSR
// pattern run with MISR compaction, golden compare and byte-wise signature readout.
module iscas89_bist_harness #(
    parameter int                N_IN      = 4,
    parameter int                N_OUT     = 1,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_POLY = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'hB400,
    parameter logic [MISR_W-1:0] MISR_SEED = '0,
    parameter int                PATTERNS  = 255,
    parameter logic [MISR_W-1:0] GOLDEN    = '0
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             mode,
    input  logic             start,
    input  logic [N_IN-1:0]  func_in,
    output logic [N_OUT-1:0] func_out,
    output logic [N_IN-1:0]  dut_pi,
    input  logic [N_OUT-1:0] dut_po,
    output logic             busy,
    output logic             done,
    output logic             pass,
    input  logic [1:0]       sig_sel,
    output logic [7:0]       sig_byte
);
    // state | meaning
    // IDLE  | functional mode or waiting for a BIST launch
    // RUN   | LFSR drives the core, MISR compacts one response per cycle
    // DONE  | signature frozen, pass valid, waiting for restart or mode=0

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [LFSR_W-1:0] LFSR_INIT = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
    localparam logic [15:0]       LAST      = 16'(PATTERNS - 1);

    if (PATTERNS < 1 || PATTERNS > 65535) begin : g_bad_patterns
        $error("iscas89_bist_harness: PATTERNS must be in 1..65535");
    end
    if (N_IN < 1 || N_IN > LFSR_W) begin : g_bad_n_in
        $error("iscas89_bist_harness: N_IN must be in 1..LFSR_W");
    end
    if (N_OUT < 1 || N_OUT > MISR_W || MISR_W < 8 || MISR_W > 32 || (MISR_W % 8) != 0) begin : g_bad_misr
        $error("iscas89_bist_harness: illegal N_OUT / MISR_W combination");
    end

    logic [1:0]        state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic [MISR_W-1:0] misr;
    logic [MISR_W-1:0] misr_next;
    logic [MISR_W-1:0] po_ext;
    logic [15:0]       count;
    logic              pass_q;
    logic [31:0]       misr_ext;

    always_comb begin
        po_ext              = '0;
        po_ext[N_OUT-1:0]   = dut_po;
        lfsr_next           = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
        misr_next           = ((misr >> 1) ^ (misr[0] ? MISR_POLY : '0)) ^ po_ext;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            lfsr   <= LFSR_INIT;
            misr   <= MISR_SEED;
            count  <= '0;
            pass_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mode && start) begin
                        state  <= S_RUN;
                        lfsr   <= LFSR_INIT;
                        misr   <= MISR_SEED;
                        count  <= '0;
                        pass_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Abort leaves the partial signature readable.
                    if (!mode) begin
                        state <= S_IDLE;
                    end else begin
                        lfsr  <= lfsr_next;
                        misr  <= misr_next;
                        count <= count + 16'd1;
                        if (count == LAST) begin
                            state  <= S_DONE;
                            pass_q <= (misr_next == GOLDEN);
                        end
                    end
                end
                S_DONE: begin
                    if (!mode) begin
                        state  <= S_IDLE;
                        pass_q <= 1'b0;
                    end else if (start) begin
                        state  <= S_RUN;
                        lfsr   <= LFSR_INIT;
                        misr   <= MISR_SEED;
                        count  <= '0;
                        pass_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    pass_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign pass = pass_q;

    always_comb begin
        if (!mode) begin
            dut_pi   = func_in;
            func_out = dut_po;
        end else begin
            dut_pi   = (state == S_RUN) ? lfsr[N_IN-1:0] : '0;
            func_out = '0;
        end
    end

    // Bytes past the top of the MISR read as zero via the padded copy.
    always_comb begin
        misr_ext             = '0;
        misr_ext[MISR_W-1:0] = misr;
        sig_byte             = misr_ext[{sig_sel, 3'b000} +: 8];
    end

endmodule

// File: tb/tb_iscas89_bist_harness.sv
// Bench for iscas89_bist_harness: random core responses, a signature model and a
// done-triggered scoreboard, on a default instance and a 2-pattern instance.
`timescale 1ns/1ps
module tb_iscas89_bist_harness;
    localparam int          P_A    = 255;
    localparam int          P_B    = 2;
    localparam logic [15:0] GOLD_B = 16'hB401;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
    } exp_t;

    logic       CK = 1'b0;
    logic       RST;
    logic       mode;
    logic       start;
    logic [3:0] func_in;
    logic [3:0] pi_a, pi_b;
    logic       po_a, po_b;
    logic       fo_a, fo_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [1:0] sel_a, sel_b;
    logic [7:0] byte_a, byte_b;

    logic [254:0] vec_a;
    logic [1:0]   vec_b;
    exp_t         q_a[$];
    exp_t         q_b[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 CK = ~CK;

    iscas89_bist_harness u_dut_a (
        .CK(CK), .RST(RST), .mode(mode), .start(start),
        .func_in(func_in), .func_out(fo_a), .dut_pi(pi_a), .dut_po(po_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .sig_sel(sel_a), .sig_byte(byte_a)
    );

    iscas89_bist_harness #(.PATTERNS(P_B), .GOLDEN(GOLD_B)) u_dut_b (
        .CK(CK), .RST(RST), .mode(mode), .start(start),
        .func_in(func_in), .func_out(fo_b), .dut_pi(pi_b), .dut_po(po_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .sig_sel(sel_b), .sig_byte(byte_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One Galois shift with the 0xB400 mask, shared rule of LFSR and MISR.
    function automatic logic [15:0] galois(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] misr_ref(input logic [254:0] v, input int n);
        logic [15:0] sig;
        sig = 16'h0000;
        for (int i = 0; i < n; i++) sig = galois(sig) ^ {15'b0, v[i]};
        return sig;
    endfunction

    // Scoreboard monitors: each completed run pops one expectation and reads all bytes.
    initial begin : mon_a
        logic prev;
        exp_t e;
        prev  = 1'b0;
        sel_a = 2'd0;
        forever begin
            @(negedge CK);
            if (done_a && !prev) begin
                if (q_a.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_unexpected_done: got done with empty queue at %0t", $time);
                end else begin
                    e = q_a.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        sel_a = 2'(i);
                        #0.5;
                        check("a_sig_byte", 32'(byte_a), (i < 2) ? 32'(e.sig[8*i +: 8]) : 32'h0);
                    end
                    sel_a = 2'd0;
                    check("a_pass", 32'(pass_a), 32'(e.pass));
                end
            end
            prev = done_a;
        end
    end

    initial begin : mon_b
        logic prev;
        exp_t e;
        prev  = 1'b0;
        sel_b = 2'd0;
        forever begin
            @(negedge CK);
            if (done_b && !prev) begin
                if (q_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_unexpected_done: got done with empty queue at %0t", $time);
                end else begin
                    e = q_b.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        sel_b = 2'(i);
                        #0.5;
                        check("b_sig_byte", 32'(byte_b), (i < 2) ? 32'(e.sig[8*i +: 8]) : 32'h0);
                    end
                    sel_b = 2'd0;
                    check("b_pass", 32'(pass_b), 32'(e.pass));
                end
            end
            prev = done_b;
        end
    end

    // Launch a run: start in cycle T, then drive n_drive RUN cycles with checks.
    task automatic launch(input int n_drive, input bit push_a);
        logic [15:0] s;
        logic [15:0] sig;
        exp_t        e;
        if (push_a) begin
            sig    = misr_ref(vec_a, P_A);
            e.sig  = sig;
            e.pass = (sig == 16'h0000);
            q_a.push_back(e);
        end
        sig    = misr_ref({253'b0, vec_b}, P_B);
        e.sig  = sig;
        e.pass = (sig == GOLD_B);
        q_b.push_back(e);

        @(posedge CK); #1;
        mode  = 1'b1;
        start = 1'b1;
        po_a  = 1'($urandom);
        po_b  = 1'($urandom);
        @(negedge CK);
        check("a_busy_at_start", 32'(busy_a), 32'h0);

        s = 16'hACE1;
        for (int i = 0; i < n_drive; i++) begin
            @(posedge CK); #1;
            start = (i < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            po_a  = vec_a[i];
            po_b  = (i < 2) ? vec_b[i] : 1'($urandom);
            @(negedge CK);
            check("a_pi_lfsr", 32'(pi_a), 32'(s[3:0]));
            check("a_busy_run", 32'(busy_a), 32'h1);
            check("a_done_run", 32'(done_a), 32'h0);
            if (i < 2) begin
                check("b_busy_run", 32'(busy_b), 32'h1);
            end else if (i == 2) begin
                check("b_busy_end", 32'(busy_b), 32'h0);
                check("b_done_end", 32'(done_b), 32'h1);
            end
            s = galois(s);
        end
        start = 1'b0;
    endtask

    task automatic expect_done_a();
        @(posedge CK); #1;
        @(negedge CK);
        check("a_done_at_end", 32'(done_a), 32'h1);
        check("a_busy_at_end", 32'(busy_a), 32'h0);
    endtask

    task automatic rand_vectors();
        vec_a = 255'({$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom});
        vec_b = 2'($urandom);
    endtask

    initial begin : stim
        RST     = 1'b1;
        mode    = 1'b0;
        start   = 1'b0;
        func_in = 4'h0;
        po_a    = 1'b0;
        po_b    = 1'b0;

        repeat (2) @(posedge CK);
        #1;
        mode = 1'b1;
        #1;
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_pass", 32'(pass_a), 32'h0);
        check("rst_sig", 32'(byte_a), 32'h0);
        check("rst_pi_bist_idle", 32'(pi_a), 32'h0);
        check("rst_fo_bist", 32'(fo_a), 32'h0);
        @(negedge CK);
        RST  = 1'b0;
        mode = 1'b0;

        for (int k = 0; k < 6; k++) begin
            @(posedge CK); #1;
            func_in = (k == 0) ? 4'hA : 4'($urandom);
            po_a    = (k == 0) ? 1'b1 : 1'($urandom);
            #1;
            check("func_pi", 32'(pi_a), 32'(func_in));
            check("func_out", 32'(fo_a), 32'(po_a));
            check("func_busy", 32'(busy_a), 32'h0);
            check("func_done", 32'(done_a), 32'h0);
        end

        // Run 1: random responses on A, tied-high responses on B.
        rand_vectors();
        vec_b = 2'b11;
        launch(P_A, 1'b1);
        expect_done_a();
        for (int k = 0; k < 10; k++) begin
            @(posedge CK); #1;
            @(negedge CK);
            check("a_done_sticky", 32'(done_a), 32'h1);
        end

        // Run 2: restart from DONE with identical A responses.
        vec_b = 2'b00;
        launch(P_A, 1'b1);
        expect_done_a();

        // Run 3: zero responses give the zero signature; mode=0 clears done.
        vec_a = '0;
        vec_b = 2'($urandom);
        launch(P_A, 1'b1);
        expect_done_a();
        @(posedge CK); #1;
        mode = 1'b0;
        @(negedge CK);
        check("a_done_before_exit", 32'(done_a), 32'h1);
        @(posedge CK); #1;
        @(negedge CK);
        check("a_done_after_exit", 32'(done_a), 32'h0);
        check("a_pass_after_exit", 32'(pass_a), 32'h0);

        // Abort in the 5th RUN cycle.
        rand_vectors();
        launch(4, 1'b0);
        @(posedge CK); #1;
        mode = 1'b0;
        @(negedge CK);
        check("abort_busy_same_cycle", 32'(busy_a), 32'h1);
        @(posedge CK); #1;
        @(negedge CK);
        check("abort_busy", 32'(busy_a), 32'h0);
        check("abort_done", 32'(done_a), 32'h0);

        // Asynchronous reset mid-run, then a fresh full run.
        rand_vectors();
        launch(6, 1'b0);
        @(posedge CK); #2;
        RST = 1'b1;
        #1;
        check("midrst_busy", 32'(busy_a), 32'h0);
        check("midrst_done", 32'(done_a), 32'h0);
        check("midrst_pass", 32'(pass_a), 32'h0);
        check("midrst_sig", 32'(byte_a), 32'h0);
        check("midrst_pi", 32'(pi_a), 32'h0);
        check("midrst_b_done", 32'(done_b), 32'h0);
        @(negedge CK);
        RST = 1'b0;
        rand_vectors();
        launch(P_A, 1'b1);
        expect_done_a();

        repeat (3) @(posedge CK);
        @(negedge CK); #3;
        check("a_queue_drained", 32'(q_a.size()), 32'h0);
        check("b_queue_drained", 32'(q_b.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
